// File: rtl/uart_raminfr.sv
// Register-file RAM behind the UART FIFOs: one synchronous write port, two
// combinational read ports (dpo at dpra, spo at the write address a).
module uart_raminfr #(
    parameter int addr_width = 4,
    parameter int data_width = 8,
    parameter int depth      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [addr_width-1:0] a,
    input  logic [addr_width-1:0] dpra,
    input  logic [data_width-1:0] di,
    output logic [data_width-1:0] dpo,
    output logic [data_width-1:0] spo
);

    // One extra bit so depth == 2**addr_width is representable.
    localparam logic [addr_width:0] DEPTH_W = (addr_width + 1)'(depth);

    logic [data_width-1:0] mem_q [depth];
    logic [data_width-1:0] mem_d [depth];

    logic a_in_range;
    logic dpra_in_range;

    assign a_in_range    = ({1'b0, a} < DEPTH_W);
    assign dpra_in_range = ({1'b0, dpra} < DEPTH_W);

    genvar gi;
    generate
        for (gi = 0; gi < depth; gi++) begin : g_word
            localparam logic [addr_width-1:0] IDX = addr_width'(gi);

            // Only in-range words exist, so an address >= depth never matches.
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (we && (a == IDX)) begin
                    mem_d[gi] = di;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    // Reads see the registered contents, giving read-before-write on a same-cycle write.
    always_comb begin
        dpo = '0;
        spo = '0;
        if (dpra_in_range) begin
            dpo = mem_q[dpra];
        end
        if (a_in_range) begin
            spo = mem_q[a];
        end
    end

endmodule

// File: tb/tb_uart_raminfr.sv
// Self-checking bench: full-depth and partial-depth instances share stimulus
// and are compared against simple array models updated per clock edge.
module tb_uart_raminfr;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [3:0] a;
    logic [3:0] dpra;
    logic [7:0] di;
    logic [7:0] dpo16, spo16, dpo10, spo10;

    int checks = 0;
    int errors = 0;

    logic [7:0] m16 [16];
    logic [7:0] m10 [10];

    always #5 clk = ~clk;

    uart_raminfr #(.addr_width(4), .data_width(8), .depth(16)) dut16 (
        .clk(clk), .rst(rst), .we(we), .a(a), .dpra(dpra), .di(di),
        .dpo(dpo16), .spo(spo16)
    );

    uart_raminfr #(.addr_width(4), .data_width(8), .depth(10)) dut10 (
        .clk(clk), .rst(rst), .we(we), .a(a), .dpra(dpra), .di(di),
        .dpo(dpo10), .spo(spo10)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd16(input int addr);
        return (addr < 16) ? m16[addr] : 8'h00;
    endfunction

    function automatic logic [7:0] rd10(input int addr);
        return (addr < 10) ? m10[addr] : 8'h00;
    endfunction

    // Apply the edge to the models, then let the DUTs see it.
    task automatic edge_step();
        if (rst) begin
            foreach (m16[i]) m16[i] = 8'h00;
            foreach (m10[i]) m10[i] = 8'h00;
        end else if (we) begin
            if (int'(a) < 16) m16[a] = di;
            if (int'(a) < 10) m10[a] = di;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        check({tag, ".dpo16"}, dpo16, rd16(int'(dpra)));
        check({tag, ".spo16"}, spo16, rd16(int'(a)));
        check({tag, ".dpo10"}, dpo10, rd10(int'(dpra)));
        check({tag, ".spo10"}, spo10, rd10(int'(a)));
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; a = '0; dpra = '0; di = '0;
        @(posedge clk);
        #1;
        edge_step();

        // Clear: fill everything, pulse reset, sweep both read ports.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; a = 4'(i); di = 8'($urandom);
            edge_step();
        end
        we = 1'b0;
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i); dpra = 4'(i);
            #1;
            check("clear.dpo", dpo16, 8'h00);
            check("clear.spo", spo16, 8'h00);
            check("clear.dpo10", dpo10, 8'h00);
        end
        $display("txn clear sweep done");

        // Write with read-before-write on the same address.
        a = 4'd3; di = 8'hA5; we = 1'b1; dpra = 4'd3;
        #1;
        check("rbw.pre_dpo", dpo16, 8'h00);
        edge_step();
        we = 1'b0;
        #1;
        check("rbw.post_dpo", dpo16, 8'hA5);
        check("rbw.post_spo", spo16, 8'hA5);
        $display("txn write a=3 di=a5");

        // Full sweep, then read back 15,0,1,... across the wrap point.
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; a = 4'(i); di = 8'(i) ^ 8'h5A;
            edge_step();
        end
        we = 1'b0;
        for (int k = 0; k < 17; k++) begin
            dpra = 4'((15 + k) % 16);
            #1;
            check("sweep.dpo", dpo16, 8'(int'(dpra)) ^ 8'h5A);
        end
        $display("txn sweep readback done");

        // FIFO push at 7 while popping 6.
        we = 1'b1; a = 4'd6; di = 8'h22;
        edge_step();
        a = 4'd7; di = 8'h11; dpra = 4'd6;
        #1;
        check("push.pre_dpo", dpo16, 8'h22);
        edge_step();
        we = 1'b0;
        #1;
        check("push.post_dpo", dpo16, 8'h22);
        check("push.post_spo", spo16, 8'h11);
        $display("txn push a=7 pop dpra=6");

        // Reset beats a simultaneous write; the next edge writes.
        we = 1'b1; a = 4'd2; di = 8'hFF; rst = 1'b1;
        edge_step();
        rst = 1'b0;
        #1;
        check("rstpri.spo", spo16, 8'h00);
        edge_step();
        we = 1'b0;
        #1;
        check("rstpri.after", spo16, 8'hFF);
        $display("txn reset priority");

        // Partial depth: write beyond depth is dropped and reads as zero.
        for (int i = 0; i < 10; i++) begin
            we = 1'b1; a = 4'(i); di = 8'(i + 1);
            edge_step();
        end
        a = 4'd12; di = 8'h77; we = 1'b1;
        edge_step();
        we = 1'b0;
        dpra = 4'd12;
        #1;
        check("part.dpo12", dpo10, 8'h00);
        check("part.spo12", spo10, 8'h00);
        for (int i = 0; i < 10; i++) begin
            dpra = 4'(i);
            #1;
            check("part.hold", dpo10, 8'(i + 1));
        end
        a = 4'd9; di = 8'h77; we = 1'b1;
        edge_step();
        we = 1'b0; dpra = 4'd9;
        #1;
        check("part.w9", dpo10, 8'h77);
        $display("txn partial depth");

        // Randomized traffic, checked before and after every edge.
        for (int n = 0; n < 300; n++) begin
            rst  = ($urandom_range(0, 29) == 0);
            we   = $urandom_range(0, 1) == 1;
            a    = 4'($urandom);
            dpra = ($urandom_range(0, 3) == 0) ? a : 4'($urandom);
            di   = 8'($urandom);
            check_all("rnd.pre");
            $display("txn %0d rst=%0b we=%0b a=%0d dpra=%0d di=%02h", n, rst, we, a, dpra, di);
            edge_step();
            check_all("rnd.post");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
